// File: rtl/register_file_if.sv
// register_file_if: control-unit strobes, register indices and the operand-2 bus.
// d_bus stays a plain inout on the file because it is a shared tri-state bus.
interface register_file_if #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
);
    logic                  reg1_read;
    logic                  reg2_read;
    logic                  reg3_write;
    logic [DEPTH_LOG2-1:0] reg1_addr;
    logic [DEPTH_LOG2-1:0] reg2_addr;
    logic [DEPTH_LOG2-1:0] reg3_addr;
    logic [WIDTH-1:0]      b_bus;

    modport master (
        output reg1_read, reg2_read, reg3_write, reg1_addr, reg2_addr, reg3_addr,
        input  b_bus
    );
    modport slave (
        input  reg1_read, reg2_read, reg3_write, reg1_addr, reg2_addr, reg3_addr,
        output b_bus
    );
endinterface

// File: rtl/register_file.sv
// register_file: 2^DEPTH_LOG2 x WIDTH register file driving d_bus (operand 1) and b_bus (operand 2),
// writing d_bus at the clock edge, with a debug read port and a committed-write counter.
module register_file #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    register_file_if.slave        bus,
    inout  wire  [WIDTH-1:0]      d_bus,
    input  logic [DEPTH_LOG2-1:0] dbg_addr,
    output logic [WIDTH-1:0]      dbg_data,
    output logic [WIDTH-1:0]      write_count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [WIDTH-1:0] r_write_count;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_wdata;

    assign w_rd1 = r_regs[bus.reg1_addr];
    // A move takes the old source value directly rather than round-tripping through the tri-state net.
    assign w_wdata = bus.reg1_read ? w_rd1 : d_bus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_write_count <= '0;
        end else if (bus.reg3_write) begin
            r_regs[bus.reg3_addr] <= w_wdata;
            r_write_count         <= r_write_count + 1'b1;
        end
    end

    assign d_bus       = bus.reg1_read ? w_rd1 : {WIDTH{1'bz}};
    assign bus.b_bus   = bus.reg2_read ? r_regs[bus.reg2_addr] : '0;
    assign dbg_data    = r_regs[dbg_addr];
    assign write_count = r_write_count;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed literal cases plus randomized traffic against an array-based model.
`timescale 1ns/100ps
module tb_register_file;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [3:0]  dbg_addr = 0;
    logic [15:0] dbg_data, write_count;
    logic        drv = 1;
    logic [15:0] drv_val = 16'h5A5A;
    wire  [15:0] d_bus;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_regs [16];
    logic [15:0] m_count;

    register_file_if rf ();
    assign d_bus = drv ? drv_val : 16'bz;

    register_file dut (
        .clk(clk), .rst_n(rst_n), .bus(rf.slave), .d_bus(d_bus),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .write_count(write_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the array holds the last value written per index; a write stores the operand-1
    // value when the file is reading, otherwise whatever the external driver puts on the bus.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_regs[i] <= 16'h0000;
            m_count <= 16'h0000;
        end else if (rf.reg3_write) begin
            m_regs[rf.reg3_addr] <= rf.reg1_read ? m_regs[rf.reg1_addr] : drv_val;
            m_count <= m_count + 16'd1;
        end
    end

    always @(negedge clk) begin
        chk("dbg_data", dbg_data, m_regs[dbg_addr]);
        chk("write_count", write_count, m_count);
        chk("b_bus", rf.b_bus, rf.reg2_read ? m_regs[rf.reg2_addr] : 16'h0000);
        chk("d_bus", d_bus, rf.reg1_read ? m_regs[rf.reg1_addr] : drv_val);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.reg1_read = 0; rf.reg2_read = 0; rf.reg3_write = 0;
        drv = 1; drv_val = 16'h5A5A;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] v);
        drv = 1; drv_val = v; rf.reg3_write = 1; rf.reg3_addr = a;
        step();
        idle();
    endtask

    initial begin
        idle();
        rf.reg1_addr = 0; rf.reg2_addr = 0; rf.reg3_addr = 0;
        @(negedge clk);
        chk("reset_count", write_count, 16'h0000);
        chk("reset_b_bus", rf.b_bus, 16'h0000);
        step();
        rst_n = 1;

        wr(4'd5, 16'hBEEF);
        dbg_addr = 5;
        @(negedge clk);
        chk("load_dbg5", dbg_data, 16'hBEEF);
        chk("load_count", write_count, 16'd1);

        wr(4'd3, 16'h1234);
        wr(4'd9, 16'h00FF);
        drv = 0; rf.reg1_read = 1; rf.reg1_addr = 3; rf.reg2_read = 1; rf.reg2_addr = 9;
        @(negedge clk);
        chk("dual_d_bus", d_bus, 16'h1234);
        chk("dual_b_bus", rf.b_bus, 16'h00FF);
        step();
        idle();
        @(negedge clk);
        chk("idle_b_bus", rf.b_bus, 16'h0000);
        chk("idle_d_bus_released", d_bus, 16'h5A5A);

        wr(4'd2, 16'hA5A5);
        drv = 0; rf.reg1_read = 1; rf.reg1_addr = 2; rf.reg3_write = 1; rf.reg3_addr = 7;
        step();
        idle();
        dbg_addr = 7;
        #1 chk("move_dst", dbg_data, 16'hA5A5);
        dbg_addr = 2;
        #1 chk("move_src", dbg_data, 16'hA5A5);
        wr(4'd4, 16'h1357);
        drv = 0; rf.reg1_read = 1; rf.reg1_addr = 4; rf.reg3_write = 1; rf.reg3_addr = 4;
        step();
        idle();
        dbg_addr = 4;
        #1 chk("self_move_val", dbg_data, 16'h1357);
        chk("self_move_count", write_count, 16'd7);

        wr(4'd6, 16'h0001);
        drv_val = 16'h0002; rf.reg3_write = 1; rf.reg3_addr = 6; rf.reg2_read = 1; rf.reg2_addr = 6;
        @(negedge clk);
        chk("rw_same_old", rf.b_bus, 16'h0001);
        step();
        rf.reg3_write = 0; drv_val = 16'h5A5A;
        @(negedge clk);
        chk("rw_same_new", rf.b_bus, 16'h0002);
        chk("rw_same_count", write_count, 16'd9);
        step();
        idle();

        for (int n = 0; n < 2000; n++) begin
            rf.reg1_read  = ($urandom_range(0, 2) == 0);
            rf.reg2_read  = $urandom_range(0, 1);
            rf.reg3_write = ($urandom_range(0, 2) != 0);
            rf.reg1_addr  = 4'($urandom);
            rf.reg2_addr  = 4'($urandom);
            rf.reg3_addr  = 4'($urandom);
            dbg_addr      = 4'($urandom);
            drv           = !rf.reg1_read;
            drv_val       = 16'($urandom);
            step();
        end
        idle();

        // Asynchronous reset mid-cycle with a write pending at the following edge.
        rf.reg3_write = 1; rf.reg3_addr = 1; drv_val = 16'hFACE;
        rst_n = 0;
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #0.5 chk("async_reset_dbg", dbg_data, 16'h0000);
        end
        chk("async_reset_count", write_count, 16'h0000);
        chk("async_reset_d_bus_released", d_bus, 16'hFACE);
        step();
        dbg_addr = 1;
        #1 chk("pending_write_discarded", dbg_data, 16'h0000);
        idle();
        rst_n = 1;

        rf.reg3_write = 1;
        for (int n = 0; n < 65536; n++) begin
            rf.reg3_addr = 4'($urandom);
            drv_val = 16'($urandom);
            step();
        end
        idle();
        @(negedge clk);
        chk("count_wrap", write_count, 16'h0000);

        for (int i = 0; i < 16; i++) wr(4'(i), 16'hC000 + 16'(i * 3));
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #0.5 chk("distinct_readback", dbg_data, 16'hC000 + 16'(i * 3));
        end
        chk("final_count", write_count, 16'd16);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
